// File: rtl/keypad_pkg.sv
// Shared keypad types: decoded key codes, operand-entry states and matrix size.
package keypad_pkg;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [4:0] {
    KEY_0, KEY_1, KEY_2, KEY_3, KEY_4, KEY_5, KEY_6, KEY_7, KEY_8, KEY_9,
    KEY_A, KEY_B, KEY_C, KEY_D, KEY_STAR, KEY_HASH, KEY_NONE
  } key_code_t;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, DONE} entry_state_t;

  function automatic logic is_digit(key_code_t k);
    return k <= KEY_9;
  endfunction
endpackage

// File: rtl/keypad_key_decoder.sv
// Combinational row/column latch to key code; anything not exactly one-hot
// on both axes decodes to KEY_NONE. Row bit 0 = top row, col bit 0 = left.
module keypad_key_decoder
  import keypad_pkg::*;
(
  input  logic [ROWS-1:0] row_lat,
  input  logic [COLS-1:0] col_lat,
  output key_code_t       key_code
);
  always_comb begin
    key_code = KEY_NONE;
    case ({row_lat, col_lat})
      8'b0001_0001: key_code = KEY_1;
      8'b0001_0010: key_code = KEY_2;
      8'b0001_0100: key_code = KEY_3;
      8'b0001_1000: key_code = KEY_A;
      8'b0010_0001: key_code = KEY_4;
      8'b0010_0010: key_code = KEY_5;
      8'b0010_0100: key_code = KEY_6;
      8'b0010_1000: key_code = KEY_B;
      8'b0100_0001: key_code = KEY_7;
      8'b0100_0010: key_code = KEY_8;
      8'b0100_0100: key_code = KEY_9;
      8'b0100_1000: key_code = KEY_C;
      8'b1000_0001: key_code = KEY_STAR;
      8'b1000_0010: key_code = KEY_0;
      8'b1000_0100: key_code = KEY_HASH;
      8'b1000_1000: key_code = KEY_D;
      default:      key_code = KEY_NONE;
    endcase
  end
endmodule

// File: rtl/keypad_operand_capture.sv
// Builds two BCD operands from keypad events and offers them under valid/ready.
// Optional macro KEYPAD_BACKSPACE_EN turns the D key into backspace.
module keypad_operand_capture
  import keypad_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                           slow_clk,
  input  logic                           rst_n,
  input  logic                           key_pressed,
  input  logic [3:0]                     row_capture,
  input  logic [3:0]                     col_shift_reg,
  output logic [4*DIGITS-1:0]            operand_a,
  output logic [4*DIGITS-1:0]            operand_b,
  output logic                           entry_sel,
  output logic [$clog2(DIGITS+1)-1:0]    digit_count,
  output logic                           operands_valid,
  input  logic                           operands_ready
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic [ROWS-1:0] row_lat;
  logic [COLS-1:0] col_lat;
  key_code_t       key;
  entry_state_t    state, state_d;
  logic [W-1:0]    a_d, b_d, cur, cur_d;
  logic [CW-1:0]   cnt_d;
  logic [3:0]      digit;

  keypad_key_decoder u_dec (
    .row_lat  (row_lat),
    .col_lat  (col_lat),
    .key_code (key)
  );

  assign digit          = key[3:0];
  assign entry_sel      = (state != ENTER_A);
  assign operands_valid = (state == DONE);
  assign cur            = (state == ENTER_B) ? operand_b : operand_a;

  always_comb begin
    state_d = state;
    a_d     = operand_a;
    b_d     = operand_b;
    cnt_d   = digit_count;
    cur_d   = cur;
    case (state)
      ENTER_A, ENTER_B: begin
        if (key_pressed) begin
          if (is_digit(key)) begin
            // A full operand swallows extra digits rather than dropping the MSD.
            if (digit_count < CW'(DIGITS)) begin
              cur_d = (cur << 4) | W'(digit);
              cnt_d = digit_count + CW'(1);
            end
          end else begin
            case (key)
              KEY_STAR: begin
                cur_d = '0;
                cnt_d = '0;
              end
              KEY_HASH: begin
                cnt_d   = '0;
                state_d = (state == ENTER_A) ? ENTER_B : DONE;
              end
`ifdef KEYPAD_BACKSPACE_EN
              KEY_D: begin
                if (digit_count != '0) begin
                  cur_d = cur >> 4;
                  cnt_d = digit_count - CW'(1);
                end
              end
`endif
              default: ;
            endcase
          end
        end
        if (state == ENTER_B) b_d = cur_d;
        else                  a_d = cur_d;
      end
      DONE: begin
        // Keys are dropped here, including one coincident with acceptance.
        if (operands_ready) begin
          state_d = ENTER_A;
          a_d     = '0;
          b_d     = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ENTER_A;
    endcase
  end

  always_ff @(posedge slow_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ENTER_A;
      operand_a   <= '0;
      operand_b   <= '0;
      digit_count <= '0;
    end else begin
      state       <= state_d;
      operand_a   <= a_d;
      operand_b   <= b_d;
      digit_count <= cnt_d;
    end
  end

  // Latch updates after decode, so a coincident scan pattern affects the next key.
  always_ff @(posedge slow_clk or negedge rst_n) begin
    if (!rst_n) begin
      row_lat <= '0;
      col_lat <= '0;
    end else if (row_capture != 4'b0) begin
      row_lat <= row_capture;
      col_lat <= col_shift_reg;
    end
  end
endmodule

// File: tb/tb_keypad_operand_capture.sv
// Table vectors, hand-written corner sequences and a randomized run against a
// digit-queue reference model of the operand-entry rules.
module tb_keypad_operand_capture;
  localparam int DIGITS = 3;

  logic        slow_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_pressed = 1'b0;
  logic [3:0]  row_capture = '0;
  logic [3:0]  col_shift_reg = '0;
  logic        operands_ready = 1'b0;
  logic [11:0] operand_a, operand_b;
  logic        entry_sel, operands_valid;
  logic [1:0]  digit_count;

  keypad_operand_capture #(.DIGITS(DIGITS)) dut (
    .slow_clk       (slow_clk),
    .rst_n          (rst_n),
    .key_pressed    (key_pressed),
    .row_capture    (row_capture),
    .col_shift_reg  (col_shift_reg),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .entry_sel      (entry_sel),
    .digit_count    (digit_count),
    .operands_valid (operands_valid),
    .operands_ready (operands_ready)
  );

  always #5 slow_clk = ~slow_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  // Reference model: each operand is the ordered list of digits typed so far.
  string KEYS = "123A456B789C*0#D";
  int    q[2][$];
  bit    m_sel, m_valid;

  function automatic void model_reset();
    q[0].delete();
    q[1].delete();
    m_sel   = 1'b0;
    m_valid = 1'b0;
  endfunction

  function automatic logic [11:0] qv(input int s);
    logic [11:0] v = '0;
    for (int i = 0; i < q[s].size(); i++) v = v * 16 + 12'(q[s][i]);
    return v;
  endfunction

  function automatic void model_step(input bit kv, input byte ch, input bit rdy);
    int s;
    if (m_valid) begin
      if (rdy) model_reset();
      return;
    end
    if (!kv) return;
    s = int'(m_sel);
    if (ch >= 8'd48 && ch <= 8'd57) begin
      if (q[s].size() < DIGITS) q[s].push_back(int'(ch) - 48);
    end else if (ch == "*") begin
      q[s].delete();
    end else if (ch == "#") begin
      if (!m_sel) m_sel = 1'b1;
      else        m_valid = 1'b1;
    end
`ifdef KEYPAD_BACKSPACE_EN
    else if (ch == "D") begin
      if (q[s].size() > 0) void'(q[s].pop_back());
    end
`endif
  endfunction

  task automatic check_model(input string tag);
    int exp_cnt;
    exp_cnt = m_valid ? 0 : q[int'(m_sel)].size();
    chk({tag, " op_a"}, operand_a, qv(0));
    chk({tag, " op_b"}, operand_b, qv(1));
    chk({tag, " sel"}, entry_sel, m_sel);
    chk({tag, " valid"}, operands_valid, m_valid);
    chk({tag, " cnt"}, digit_count, exp_cnt);
  endtask

  // One keypress: scan cycle with the pattern, then the key_pressed pulse.
  task automatic press_raw(input logic [3:0] r, input logic [3:0] c,
                           input bit rdy_scan, input bit rdy_key);
    bit  kv;
    byte ch;
    kv = $onehot(r) && $onehot(c);
    ch = kv ? KEYS[$clog2(r) * 4 + $clog2(c)] : 8'd0;
    row_capture = r; col_shift_reg = c; operands_ready = rdy_scan;
    tick();
    model_step(1'b0, 8'd0, rdy_scan);
    row_capture = '0; col_shift_reg = '0; key_pressed = 1'b1; operands_ready = rdy_key;
    tick();
    model_step(kv, ch, rdy_key);
    key_pressed = 1'b0; operands_ready = 1'b0;
  endtask

  task automatic press(input logic [3:0] r, input logic [3:0] c);
    press_raw(r, c, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [3:0]  r, c;
    logic [11:0] a, b;
    logic        sel;
    logic [1:0]  cnt;
    logic        vld;
  } vec_t;

  vec_t tbl[$];

  task automatic run_vec(input int i);
    press(tbl[i].r, tbl[i].c);
    chk($sformatf("vec%0d op_a", i), operand_a, tbl[i].a);
    chk($sformatf("vec%0d op_b", i), operand_b, tbl[i].b);
    chk($sformatf("vec%0d sel", i), entry_sel, tbl[i].sel);
    chk($sformatf("vec%0d cnt", i), digit_count, tbl[i].cnt);
    chk($sformatf("vec%0d valid", i), operands_valid, tbl[i].vld);
  endtask

  initial begin
    //                 r      c      a       b       sel   cnt    vld
    tbl.push_back(vec_t'{4'h1, 4'h1, 12'h001, 12'h000, 1'b0, 2'd1, 1'b0}); // 1
    tbl.push_back(vec_t'{4'h1, 4'h2, 12'h012, 12'h000, 1'b0, 2'd2, 1'b0}); // 2
    tbl.push_back(vec_t'{4'h8, 4'h4, 12'h012, 12'h000, 1'b1, 2'd0, 1'b0}); // #
    tbl.push_back(vec_t'{4'h1, 4'h4, 12'h012, 12'h003, 1'b1, 2'd1, 1'b0}); // 3
    tbl.push_back(vec_t'{4'h2, 4'h1, 12'h012, 12'h034, 1'b1, 2'd2, 1'b0}); // 4
    tbl.push_back(vec_t'{4'h2, 4'h2, 12'h012, 12'h345, 1'b1, 2'd3, 1'b0}); // 5
    tbl.push_back(vec_t'{4'h8, 4'h4, 12'h012, 12'h345, 1'b1, 2'd0, 1'b1}); // #
    tbl.push_back(vec_t'{4'h4, 4'h4, 12'h009, 12'h000, 1'b0, 2'd1, 1'b0}); // 9
    tbl.push_back(vec_t'{4'h4, 4'h2, 12'h098, 12'h000, 1'b0, 2'd2, 1'b0}); // 8
    tbl.push_back(vec_t'{4'h4, 4'h1, 12'h987, 12'h000, 1'b0, 2'd3, 1'b0}); // 7
    tbl.push_back(vec_t'{4'h2, 4'h4, 12'h987, 12'h000, 1'b0, 2'd3, 1'b0}); // 6 dropped
    tbl.push_back(vec_t'{4'h8, 4'h1, 12'h000, 12'h000, 1'b0, 2'd0, 1'b0}); // *
    tbl.push_back(vec_t'{4'h2, 4'h2, 12'h005, 12'h000, 1'b0, 2'd1, 1'b0}); // 5
    tbl.push_back(vec_t'{4'h8, 4'h1, 12'h000, 12'h000, 1'b0, 2'd0, 1'b0}); // *
    tbl.push_back(vec_t'{4'h4, 4'h1, 12'h007, 12'h000, 1'b0, 2'd1, 1'b0}); // 7
    tbl.push_back(vec_t'{4'h1, 4'h8, 12'h007, 12'h000, 1'b0, 2'd1, 1'b0}); // A
    tbl.push_back(vec_t'{4'h2, 4'h8, 12'h007, 12'h000, 1'b0, 2'd1, 1'b0}); // B
    tbl.push_back(vec_t'{4'h4, 4'h8, 12'h007, 12'h000, 1'b0, 2'd1, 1'b0}); // C
    tbl.push_back(vec_t'{4'h3, 4'h1, 12'h007, 12'h000, 1'b0, 2'd1, 1'b0}); // two rows
    tbl.push_back(vec_t'{4'h1, 4'h5, 12'h007, 12'h000, 1'b0, 2'd1, 1'b0}); // two cols
    tbl.push_back(vec_t'{4'h8, 4'h4, 12'h007, 12'h000, 1'b1, 2'd0, 1'b0}); // #
    tbl.push_back(vec_t'{4'h8, 4'h4, 12'h007, 12'h000, 1'b1, 2'd0, 1'b1}); // # empty B
    tbl.push_back(vec_t'{4'h1, 4'h1, 12'h007, 12'h000, 1'b1, 2'd0, 1'b1}); // 1 in DONE

    // Reset state, asynchronous before any clock edge.
    #2;
    chk("rst op_a", operand_a, 0);
    chk("rst op_b", operand_b, 0);
    chk("rst sel", entry_sel, 0);
    chk("rst cnt", digit_count, 0);
    chk("rst valid", operands_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i);

    // Operands held while valid and not ready.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold%0d valid", i), operands_valid, 1);
      chk($sformatf("hold%0d op_a", i), operand_a, 12'h012);
      chk($sformatf("hold%0d op_b", i), operand_b, 12'h345);
    end
    operands_ready = 1'b1;
    tick();
    operands_ready = 1'b0;
    chk("accept valid", operands_valid, 0);
    chk("accept op_a", operand_a, 0);
    chk("accept op_b", operand_b, 0);
    chk("accept sel", entry_sel, 0);

    for (int i = 7; i < tbl.size(); i++) run_vec(i);

    // Key coincident with acceptance is lost.
    press_raw(4'h1, 4'h1, 1'b0, 1'b1);
    chk("acckey valid", operands_valid, 0);
    chk("acckey op_a", operand_a, 0);
    chk("acckey cnt", digit_count, 0);
    chk("acckey sel", entry_sel, 0);

    // Scan pattern in the key_pressed cycle: decode sees the old latch.
    row_capture = 4'h1; col_shift_reg = 4'h2;
    tick();
    row_capture = 4'h1; col_shift_reg = 4'h1; key_pressed = 1'b1;
    tick();
    chk("oldlatch op_a", operand_a, 12'h002);
    row_capture = '0; col_shift_reg = '0;
    tick();
    key_pressed = 1'b0;
    chk("newlatch op_a", operand_a, 12'h021);
    chk("newlatch cnt", digit_count, 2);

`ifdef KEYPAD_BACKSPACE_EN
    press(4'h8, 4'h8);
    chk("bs1 op_a", operand_a, 12'h002);
    chk("bs1 cnt", digit_count, 1);
    press(4'h8, 4'h8);
    chk("bs2 op_a", operand_a, 12'h000);
    chk("bs2 cnt", digit_count, 0);
    press(4'h8, 4'h8);
    chk("bs0 op_a", operand_a, 12'h000);
    chk("bs0 cnt", digit_count, 0);
`else
    press(4'h8, 4'h8);
    chk("D op_a", operand_a, 12'h021);
    chk("D cnt", digit_count, 2);
`endif

    // Asynchronous reset mid-entry (B partially typed).
    press(4'h8, 4'h4);
    press(4'h1, 4'h4);
    rst_n = 1'b0;
    #2;
    chk("midrst op_a", operand_a, 0);
    chk("midrst op_b", operand_b, 0);
    chk("midrst sel", entry_sel, 0);
    chk("midrst cnt", digit_count, 0);
    chk("midrst valid", operands_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized keys and handshakes against the model.
    model_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        bit rdy;
        rdy = ($urandom_range(0, 2) == 0);
        operands_ready = rdy;
        tick();
        model_step(1'b0, 8'd0, rdy);
        operands_ready = 1'b0;
      end else begin
        int idx;
        logic [3:0] r, c;
        idx = $urandom_range(0, 15);
        if ($urandom_range(0, 5) == 0) idx = 14;
        r = 4'h1 << (idx / 4);
        c = 4'h1 << (idx % 4);
        if ($urandom_range(0, 15) == 0) r = r | (4'h1 << ((idx / 4 + 1) % 4));
        press_raw(r, c, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      end
      check_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_operand_capture.md
# keypad_operand_capture

Consumes the debounced key events from the keypad scan FSM and builds two multi-digit BCD operands for the adder datapath. Each accepted key is decoded from the latched row and column patterns. Digits shift into the operand being edited; `*` clears it and `#` commits it. Once both operands are committed, they are presented downstream under a valid/ready handshake.

## Interface
Parameters:
- `DIGITS`, default 3: BCD digits per operand, legal range 1–8.

Ports:
- `slow_clk`, input, 1: scan-domain clock. One clock; all state is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `key_pressed`, input, 1: one-cycle pulse for a confirmed keypress. It arrives the cycle after the row pattern is presented.
- `row_capture`, input, 4: active row pattern. Nonzero only during the scan cycle.
- `col_shift_reg`, input, 4: one-hot driven column, valid in the same cycle as `row_capture`.
- `operand_a`, output, 4*DIGITS: BCD operand A, with the least significant digit in bits [3:0].
- `operand_b`, output, 4*DIGITS: BCD operand B.
- `entry_sel`, output, 1: operand currently being edited (0 = A, 1 = B).
- `digit_count`, output, $clog2(DIGITS+1): number of digits entered in the operand being edited.
- `operands_valid`, output, 1: both operands are committed and stable.
- `operands_ready`, input, 1: downstream accepts the operands.

## Operation
- Pattern latch: in any cycle where `row_capture != 0`, register `row_capture` and `col_shift_reg` into `row_lat` and `col_lat`.
  - Both latches reset to 0.
- Key decode: on `key_pressed`, decode `row_lat` and `col_lat`. Row bit 0 is the top row; column bit 0 is the leftmost column.
  - Row 0: `1 2 3 A`
  - Row 1: `4 5 6 B`
  - Row 2: `7 8 9 C`
  - Row 3: `* 0 # D`
  - If either latch is not exactly one-hot, the key is KEY_NONE and is ignored.
- State machine states: ENTER_A, ENTER_B, DONE. Reset state is ENTER_A.
- Digit key in ENTER_A or ENTER_B:
  - If `digit_count < DIGITS`: the operand becomes `{operand[4*DIGITS-5:0], digit}` and `digit_count` increments.
  - Otherwise the digit is ignored; nothing wraps and nothing is truncated.
- `*` in ENTER_A or ENTER_B: clear the active operand and set `digit_count` to 0.
- `#` in ENTER_A: go to ENTER_B and set `digit_count` to 0. Committing an empty operand is legal; its value is 0.
- `#` in ENTER_B: go to DONE and assert `operands_valid`.
- `A`, `B`, `C` are always ignored. `D` is ignored unless the Configuration macro is defined.
- DONE state:
  - Every key is ignored.
  - `operand_a` and `operand_b` are held stable.
  - When `operands_valid && operands_ready` at a rising edge: deassert `operands_valid`, clear both operands, set `digit_count` to 0, go to ENTER_A.
- `entry_sel` is 1 in ENTER_B and DONE, and 0 in ENTER_A.
- Reset values, effective immediately on `rst_n` low: all outputs 0, state ENTER_A.
  - Reset mid-entry discards partial operands.

## Timing
- A key's effect is visible on the outputs 1 cycle after the `key_pressed` edge. Latency from the `row_capture` cycle is 2 cycles.
- `operands_valid` rises 1 cycle after the `#` that commits B.
- Handshake follows valid/ready rules:
  - `operands_valid` stays high until accepted.
  - Operands do not change while valid is high.
  - `operands_ready` may be high before valid; acceptance then happens on the first edge where valid is high.
- `key_pressed` at the same edge as acceptance is ignored, because the state is DONE at that edge.
- `row_capture` nonzero in the same cycle as `key_pressed`: the decode uses the old latch; the latch updates afterwards.

## Configuration
- Macro: `KEYPAD_BACKSPACE_EN`.
- Defined: `D` in ENTER_A or ENTER_B is backspace. If `digit_count > 0`, the operand shifts right 4 bits (zero fill in the top digit) and `digit_count` decrements. If `digit_count == 0`, nothing changes.
- Undefined: `D` is ignored like `A`, `B`, `C`, and no backspace logic is synthesized.

## Structure
- Shared package `keypad_pkg` contains:
  - `key_code_t` enum: KEY_0–KEY_9, KEY_A–KEY_D, KEY_STAR, KEY_HASH, KEY_NONE.
  - `entry_state_t` enum: ENTER_A, ENTER_B, DONE.
  - `ROWS` and `COLS` constants, both 4.
- One sub-module, `keypad_key_decoder`: combinational, `row_lat`/`col_lat` to `key_code_t`, including the one-hot check. It is reused by the display path.

## Test plan
- Keys 1,2,#,3,4,5,# with DIGITS=3, `operands_ready` low:
  - `operand_a` = 0x012, `operand_b` = 0x345, `operands_valid` = 1, held for 10 cycles.
  - Then `operands_ready` = 1 for one cycle: valid drops, both operands become 0, `entry_sel` = 0.
- Keys 9,8,7,6 in ENTER_A: `operand_a` = 0x987, `digit_count` = 3; the 4th digit is ignored.
- Keys 5,*,7: `operand_a` = 0x007, `digit_count` = 1. Keys A,B,C: no change.
- In DONE, press 1 on the same edge that `operands_ready` is first seen: the operands are accepted and the key is lost, so `operand_a` = 0 afterwards.
- Row pattern 4'b0011 then `key_pressed`: ignored. Assert `rst_n` low mid-entry: all outputs 0 asynchronously.
- With `KEYPAD_BACKSPACE_EN`:
  - Keys 1,2,D: `operand_a` = 0x001, `digit_count` = 1.
  - D at count 0: no change.
  - Without the macro, D causes no change.
